// File: rtl/mcctrl_pkg.sv
// mcctrl_pkg: shared encodings for the multicycle control unit.
//   - FSM state encoding (4-bit, exposed on the State debug port)
//   - Op field codes, condition codes
//   - ALUControl / ResultSrc / ALUSrcB encodings
//   - alu_decode(): data-processing Funct -> {ALUControl, FlagW}
// Optional build macro used by the top: MCCTRL_MEM_WAIT_EN.
package mcctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Returns {ALUControl, FlagW}; FlagW[1] enables NZ, FlagW[0] enables CV.
  // Unknown commands fall back to ADD and never touch the flags.
  function automatic logic [3:0] alu_decode(input logic [5:0] funct);
    logic [1:0] ctl;
    logic [1:0] fw;
    case (funct[4:1])
      4'b0100: begin ctl = ALU_ADD; fw = {funct[0], funct[0]}; end
      4'b0010: begin ctl = ALU_SUB; fw = {funct[0], funct[0]}; end
      4'b0000: begin ctl = ALU_AND; fw = {funct[0], 1'b0};     end
      4'b1100: begin ctl = ALU_ORR; fw = {funct[0], 1'b0};     end
      default: begin ctl = ALU_ADD; fw = 2'b00;                end
    endcase
    return {ctl, fw};
  endfunction

endpackage

// File: rtl/cond_unit.sv
// cond_unit: conditional-execution unit.
//   Holds the NZCV flag register and the CondOK register.
//   clk, rst_n   : clock, async active-low reset
//   cond         : Instr[31:28]
//   alu_flags    : NZCV produced by the ALU this cycle
//   decode_en    : high in DECODE, CondOK captured at the end of that cycle
//   exec_en      : high in EXECR/EXECI, flags may load at the end of that cycle
//   flag_w       : {NZ enable, CV enable} from the ALU decoder
//   cond_ok      : registered CondOK, stable from DECODE to the next DECODE
//   cond_eval    : combinational condition result against the stored flags
module cond_unit
  import mcctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       decode_en,
  input  logic       exec_en,
  input  logic [1:0] flag_w,
  output logic       cond_ok,
  output logic       cond_eval
);

  logic [3:0] flags_r;   // {N, Z, C, V}
  logic       cond_ok_r;

  // ARM condition table; 1111 is treated as never.
  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    {n, z, cy, v} = f;
    case (c)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = cy;
      COND_CC: r = ~cy;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = cy & ~z;
      COND_LS: r = ~cy | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cond_eval = cond_check(cond, flags_r);
  assign cond_ok   = cond_ok_r;

  // Flag and CondOK state; a flag write needs the instruction's own CondOK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r   <= FLAGS_RST;
      cond_ok_r <= 1'b0;
    end else begin
      if (decode_en) cond_ok_r <= cond_eval;
      if (exec_en && cond_ok_r && flag_w[1]) flags_r[3:2] <= alu_flags[3:2];
      if (exec_en && cond_ok_r && flag_w[0]) flags_r[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the shared-memory multicycle
// ARM-subset datapath, with ALU decode and conditional execution.
//   Inputs : clk, rst_n (async active-low), Cond, Op, Funct, Rd (from the
//            instruction register), ALUFlags (NZCV from the ALU)
//            MemReady (only with MCCTRL_MEM_WAIT_EN defined)
//   Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//            ALUControl, ImmSrc, RegSrc, RegWrite, State (debug)
// Build macro MCCTRL_MEM_WAIT_EN: FETCH/MEMREAD/MEMWRITE wait for MemReady.
// The control word is registered alongside the state: it is computed from
// the state being entered, so each output is a flop (ImmSrc/RegSrc are pure
// decodes of Op and must track the instruction register directly).
module multicycle_ctrl
  import mcctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
`ifdef MCCTRL_MEM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite,
  output logic [3:0] State
);

  state_t     state_r, state_s;
  logic       pcwrite_r, adrsrc_r, memwrite_r, irwrite_r, alusrca_r, regwrite_r;
  logic [1:0] resultsrc_r, alusrcb_r, alucontrol_r;
  logic       pcwrite_s, adrsrc_s, memwrite_s, irwrite_s, alusrca_s, regwrite_s;
  logic [1:0] resultsrc_s, alusrcb_s, alucontrol_s;

  logic       mem_ready_s, fetch_gate_s, exec_s, rd_pc_s;
  logic       cond_ok_s, cond_eval_s, cond_use_s;
  logic [3:0] alu_dec_s;
  logic [1:0] flagw_s;

`ifdef MCCTRL_MEM_WAIT_EN
  assign mem_ready_s = MemReady;
`else
  assign mem_ready_s = 1'b1;
`endif

  assign alu_dec_s = alu_decode(Funct);
  assign flagw_s   = alu_dec_s[1:0];
  assign exec_s    = (state_r == S_EXECR) || (state_r == S_EXECI);
  assign rd_pc_s   = (Rd == 4'd15);
  // Outputs entered from DECODE see the condition result that is being
  // latched on this same edge; later states use the held value.
  assign cond_use_s = (state_r == S_DECODE) ? cond_eval_s : cond_ok_s;

  cond_unit #(.FLAGS_RST(FLAGS_RST)) u_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond      (Cond),
    .alu_flags (ALUFlags),
    .decode_en (state_r == S_DECODE),
    .exec_en   (exec_s),
    .flag_w    (flagw_s),
    .cond_ok   (cond_ok_s),
    .cond_eval (cond_eval_s)
  );

  // Next-state selection
  always_comb begin
    state_s = S_FETCH;
    case (state_r)
      S_FETCH:    state_s = mem_ready_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_DP:   state_s = Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_s = S_MEMADR;
          OP_BR:   state_s = S_BRANCH;
          default: state_s = S_FETCH;  // undefined op runs as a NOP
        endcase
      end
      S_MEMADR:   state_s = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_s = mem_ready_s ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_s = S_FETCH;
      S_MEMWRITE: state_s = mem_ready_s ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_s = S_ALUWB;
      S_EXECI:    state_s = S_ALUWB;
      S_ALUWB:    state_s = S_FETCH;
      S_BRANCH:   state_s = S_FETCH;
      default:    state_s = S_FETCH;
    endcase
  end

  // Control word for the state about to be entered
  always_comb begin
    pcwrite_s    = 1'b0;
    adrsrc_s     = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    alusrca_s    = 1'b0;
    regwrite_s   = 1'b0;
    resultsrc_s  = RES_ALUOUT;
    alusrcb_s    = SRCB_RD2;
    alucontrol_s = ALU_ADD;
    case (state_s)
      S_FETCH: begin
        pcwrite_s   = 1'b1;
        irwrite_s   = 1'b1;
        alusrca_s   = 1'b1;
        alusrcb_s   = SRCB_FOUR;
        resultsrc_s = RES_ALU;
      end
      S_DECODE: begin
        alusrca_s   = 1'b1;
        alusrcb_s   = SRCB_FOUR;
        resultsrc_s = RES_ALU;
      end
      S_MEMADR:   alusrcb_s = SRCB_IMM;
      S_MEMREAD:  adrsrc_s  = 1'b1;
      S_MEMWB: begin
        resultsrc_s = RES_DATA;
        regwrite_s  = cond_use_s;
        pcwrite_s   = cond_use_s & rd_pc_s;
      end
      S_MEMWRITE: begin
        adrsrc_s   = 1'b1;
        memwrite_s = cond_use_s;
      end
      S_EXECR:    alucontrol_s = alu_dec_s[3:2];
      S_EXECI: begin
        alusrcb_s    = SRCB_IMM;
        alucontrol_s = alu_dec_s[3:2];
      end
      S_ALUWB: begin
        regwrite_s = cond_use_s;
        pcwrite_s  = cond_use_s & rd_pc_s;
      end
      S_BRANCH: begin
        alusrcb_s   = SRCB_IMM;
        resultsrc_s = RES_ALU;
        pcwrite_s   = cond_use_s;
      end
      default:    pcwrite_s = 1'b0;
    endcase
  end

  // State and registered control word; reset lands on the FETCH word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_FETCH;
      pcwrite_r    <= 1'b1;
      irwrite_r    <= 1'b1;
      adrsrc_r     <= 1'b0;
      memwrite_r   <= 1'b0;
      alusrca_r    <= 1'b1;
      regwrite_r   <= 1'b0;
      resultsrc_r  <= RES_ALU;
      alusrcb_r    <= SRCB_FOUR;
      alucontrol_r <= ALU_ADD;
    end else begin
      state_r      <= state_s;
      pcwrite_r    <= pcwrite_s;
      irwrite_r    <= irwrite_s;
      adrsrc_r     <= adrsrc_s;
      memwrite_r   <= memwrite_s;
      alusrca_r    <= alusrca_s;
      regwrite_r   <= regwrite_s;
      resultsrc_r  <= resultsrc_s;
      alusrcb_r    <= alusrcb_s;
      alucontrol_r <= alucontrol_s;
    end
  end

  // FETCH enables reset to 1 so the first cycle after release fetches;
  // rst_n masks them while reset is held, MemReady masks them while waiting.
  assign fetch_gate_s = mem_ready_s | (state_r != S_FETCH);
  assign PCWrite    = pcwrite_r & fetch_gate_s & rst_n;
  assign IRWrite    = irwrite_r & fetch_gate_s & rst_n;
  assign AdrSrc     = adrsrc_r;
  assign MemWrite   = memwrite_r;
  assign RegWrite   = regwrite_r;
  assign ResultSrc  = resultsrc_r;
  assign ALUSrcA    = alusrca_r;
  assign ALUSrcB    = alusrcb_r;
  assign ALUControl = alucontrol_r;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == OP_MEM), (Op == OP_BR)};
  assign State      = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: each row holds the instruction
// fields and ALUFlags for one clock and the control word expected in it.
module tb_multicycle_ctrl;

  localparam logic [3:0] NOISE = 4'b1111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] State;
`ifdef MCCTRL_MEM_WAIT_EN
  logic       MemReady;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.FLAGS_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags),
`ifdef MCCTRL_MEM_WAIT_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .RegWrite(RegWrite), .State(State)
  );

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  flg;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          applied = 0;
  int          miscompares = 0;
  logic [15:0] e_f, e_d, e_rst;
  logic [15:0] act;

  assign act = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, RegWrite};

  function automatic logic [15:0] e(input logic [3:0] st, input logic pcw,
      input logic adr, input logic mw, input logic irw, input logic [1:0] res,
      input logic sa, input logic [1:0] sb, input logic [1:0] alu, input logic rw);
    return {st, pcw, adr, mw, irw, res, sa, sb, alu, rw};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic add(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                     input logic [3:0] r, input logic [3:0] fl, input logic [15:0] x);
    vec_t v;
    v.cond = c; v.op = o; v.funct = f; v.rd = r; v.flg = fl; v.exp = x;
    vecs.push_back(v);
  endtask

  // Data-processing: FETCH, DECODE, EXEC (st/sb/alu given), ALUWB
  task automatic dp(input logic [3:0] c, input logic [5:0] f, input logic [3:0] r,
                    input logic [3:0] fl, input logic [3:0] st, input logic [1:0] sb,
                    input logic [1:0] alu, input logic rw);
    add(c, 2'b00, f, r, NOISE, e_f);
    add(c, 2'b00, f, r, NOISE, e_d);
    add(c, 2'b00, f, r, fl, e(st, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, sb, alu, 1'b0));
    add(c, 2'b00, f, r, NOISE, e(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, rw));
  endtask

  task automatic ldr(input logic [3:0] c, input logic [5:0] f, input logic [3:0] r,
                     input logic pcw, input logic rw);
    add(c, 2'b01, f, r, NOISE, e_f);
    add(c, 2'b01, f, r, NOISE, e_d);
    add(c, 2'b01, f, r, NOISE, e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0));
    add(c, 2'b01, f, r, NOISE, e(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    add(c, 2'b01, f, r, NOISE, e(4'd4, pcw, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, rw));
  endtask

  task automatic str(input logic [3:0] c, input logic [5:0] f, input logic [3:0] r,
                     input logic mw);
    add(c, 2'b01, f, r, NOISE, e_f);
    add(c, 2'b01, f, r, NOISE, e_d);
    add(c, 2'b01, f, r, NOISE, e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0));
    add(c, 2'b01, f, r, NOISE, e(4'd5, 1'b0, 1'b1, mw, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
  endtask

  task automatic br(input logic [3:0] c, input logic pcw);
    add(c, 2'b10, 6'b100000, 4'd0, NOISE, e_f);
    add(c, 2'b10, 6'b100000, 4'd0, NOISE, e_d);
    add(c, 2'b10, 6'b100000, 4'd0, NOISE, e(4'd9, pcw, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 1'b0));
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] fl);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = fl;
  endtask

  initial begin
    e_f   = e(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0);
    e_d   = e(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0);
    e_rst = e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0);

    dp(4'b1110, 6'b001000, 4'd1, NOISE,   4'd6, 2'b00, 2'b00, 1'b1); // ADD R1,R2,R3
    dp(4'b1110, 6'b100101, 4'd1, 4'b0100, 4'd7, 2'b01, 2'b01, 1'b1); // SUBS imm -> Z
    dp(4'b0000, 6'b001000, 4'd2, NOISE,   4'd6, 2'b00, 2'b00, 1'b1); // ADDEQ taken
    dp(4'b0001, 6'b001000, 4'd2, NOISE,   4'd6, 2'b00, 2'b00, 1'b0); // ADDNE skipped
    ldr(4'b1110, 6'b011001, 4'd3, 1'b0, 1'b1);                       // LDR
    str(4'b1110, 6'b011000, 4'd3, 1'b1);                             // STR
    br(4'b1111, 1'b0);                                               // B never
    br(4'b1110, 1'b1);                                               // B always
    ldr(4'b1110, 6'b011001, 4'd15, 1'b1, 1'b1);                      // LDR PC
    add(4'b1110, 2'b11, 6'b000000, 4'd0, NOISE, e_f);                // undefined op
    add(4'b1110, 2'b11, 6'b000000, 4'd0, NOISE, e_d);
    dp(4'b1110, 6'b000001, 4'd4, 4'b1011, 4'd6, 2'b00, 2'b10, 1'b1); // ANDS: NZ only
    dp(4'b0100, 6'b001000, 4'd5, NOISE,   4'd6, 2'b00, 2'b00, 1'b1); // ADDMI taken
    dp(4'b0010, 6'b001000, 4'd5, NOISE,   4'd6, 2'b00, 2'b00, 1'b0); // ADDCS, C kept 0
    dp(4'b1110, 6'b111111, 4'd6, 4'b0110, 4'd7, 2'b01, 2'b00, 1'b1); // bad cmd: ADD, no flags
    dp(4'b0000, 6'b001000, 4'd7, NOISE,   4'd6, 2'b00, 2'b00, 1'b0); // ADDEQ, Z=0
    str(4'b0000, 6'b011000, 4'd3, 1'b0);                             // STREQ skipped
    dp(4'b1110, 6'b011000, 4'd8, NOISE,   4'd6, 2'b00, 2'b11, 1'b1); // ORR

    rst_n = 1'b0;
`ifdef MCCTRL_MEM_WAIT_EN
    MemReady = 1'b1;
`endif
    drive(4'b1110, 2'b00, 6'b001000, 4'd1, NOISE);
    repeat (2) @(negedge clk);
    #1;
    check("reset_word", act, e_rst);
    check("reset_flags", {12'd0, dut.u_cond.flags_r}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].cond, vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].flg);
      #1;
      check($sformatf("vec%0d", i), act, vecs[i].exp);
      check($sformatf("srcdec%0d", i), {12'd0, ImmSrc, RegSrc},
            {12'd0, vecs[i].op, (vecs[i].op == 2'b01), (vecs[i].op == 2'b10)});
    end

    // Reset in the middle of a store
    drive(4'b1110, 2'b01, 6'b011000, 4'd3, NOISE);
    @(negedge clk); #1 check("mr_fetch", act, e_f);
    @(negedge clk); #1 check("mr_decode", act, e_d);
    @(negedge clk); #1 check("mr_memadr", act, e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0));
    @(negedge clk); #1 check("mr_memwrite", act, e(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    check("flags_before_rst", {12'd0, dut.u_cond.flags_r}, 16'h0008);
    #1 rst_n = 1'b0;
    #1 check("mr_drop", act, e_rst);
    check("mr_flags", {12'd0, dut.u_cond.flags_r}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1 check("mr_refetch", act, e_f);
    @(negedge clk); #1 check("mr_redecode", act, e_d);

`ifdef MCCTRL_MEM_WAIT_EN
    // FETCH stalls while memory is not ready
    rst_n = 1'b0;
    @(posedge clk);
    #1 begin rst_n = 1'b1; MemReady = 1'b0; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("wait_state%0d", k), {12'd0, State}, 16'd0);
      check($sformatf("wait_irw%0d", k), {15'd0, IRWrite}, 16'd0);
    end
    MemReady = 1'b1;
    #1 check("wait_irw_pulse", {15'd0, IRWrite}, 16'd1);
    @(negedge clk); #1;
    check("wait_decode", {12'd0, State}, 16'd1);
    check("wait_irw_off", {15'd0, IRWrite}, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
